uart_frame_ctrl: RTL

Sequences the UART receive-side frame buffer.
- Takes byte strobes from the UART receiver and writes them into the 8-bit frame buffer.
- Counts bytes, verifies a trailing XOR checksum and drops stalled or corrupt frames.
- Drains the payload to a downstream consumer (loader or processor I/O port) over a valid/ready handshake.
- Controls the buffer's pointer clear, write strobe and read address.

---
 rtl/uart_frame_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_frame_ctrl
//
// Receive-side frame sequencer for a UART link. Bytes strobed in by the UART
// receiver are written into an external 8-bit frame buffer. A frame is
// FRAME_LEN bytes; the last byte is an XOR checksum chosen so that the XOR of
// the whole frame is zero. Complete, valid frames have their payload
// (FRAME_LEN-1 bytes) drained to a downstream consumer over valid/ready.
// Stalled partial frames (no byte for TIMEOUT_CYC cycles) and frames with a
// bad checksum are dropped and flagged.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx_done    one-cycle strobe, rx_data valid
//   rx_data    received byte
//   buf_clr    one-cycle pulse, buffer write pointer back to 0
//   buf_wr     buffer write strobe
//   buf_wdata  buffer write data
//   buf_raddr  buffer read address (drain index, 0 outside a drain)
//   buf_rdata  buffer read data, combinational from buf_raddr
//   out_valid  out_data valid
//   out_data   payload byte
//   out_last   final payload byte of the frame, qualified by out_valid
//   out_ready  consumer accepts the byte
//   frame_err  sticky until the next frame starts: last frame was dropped
//   ovr        sticky until reset: a byte arrived while not receiving
//   busy       sequencer is anywhere but IDLE
// -----------------------------------------------------------------------------
module uart_frame_ctrl #(
    parameter int FRAME_LEN   = 5,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       buf_clr,
    output logic       buf_wr,
    output logic [7:0] buf_wdata,
    output logic [2:0] buf_raddr,
    input  logic [7:0] buf_rdata,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       ovr,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_CLR   = 3'd0,
        S_IDLE  = 3'd1,
        S_RECV  = 3'd2,
        S_CHECK = 3'd3,
        S_FETCH = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam logic [2:0]       FRAME_LEN_V  = 3'(FRAME_LEN);
    localparam logic [2:0]       LAST_IDX_V   = 3'(FRAME_LEN - 2);
    localparam logic [CNT_W-1:0] TIMEOUT_V    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_M1_V = CNT_W'(TIMEOUT_CYC - 1);

    // Running checksum: fold one more byte into the XOR accumulator.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc,
                                            input logic [7:0] data);
        return acc ^ data;
    endfunction

    // A frame is intact when the XOR over every byte, checksum included, is 0.
    function automatic logic checksum_ok(input logic [7:0] acc);
        return (acc == 8'h00);
    endfunction

    // Inter-byte timer advance; saturates instead of wrapping.
    function automatic logic [CNT_W-1:0] timer_step(input logic [CNT_W-1:0] t);
        logic [CNT_W-1:0] nxt;
        if (t >= TIMEOUT_V) begin
            nxt = TIMEOUT_V;
        end else begin
            nxt = t + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    state_t           state_r;
    logic [2:0]       byte_cnt_r;
    logic [2:0]       rd_idx_r;
    logic [7:0]       xor_acc_r;
    logic [CNT_W-1:0] timer_r;

    logic             buf_clr_r;
    logic             buf_wr_r;
    logic [7:0]       buf_wdata_r;
    logic             out_valid_r;
    logic [7:0]       out_data_r;
    logic             out_last_r;
    logic             frame_err_r;
    logic             ovr_r;
    logic             busy_r;

    // Frame sequencer: state, counters and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_CLR;
            byte_cnt_r  <= 3'd0;
            rd_idx_r    <= 3'd0;
            xor_acc_r   <= 8'h00;
            timer_r     <= '0;
            buf_clr_r   <= 1'b0;
            buf_wr_r    <= 1'b0;
            buf_wdata_r <= 8'h00;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
            frame_err_r <= 1'b0;
            ovr_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // Pulses default low; busy is recomputed from the state being entered.
            buf_clr_r <= 1'b0;
            buf_wr_r  <= 1'b0;
            busy_r    <= 1'b1;

            case (state_r)
                S_CLR: begin
                    buf_clr_r  <= 1'b1;
                    byte_cnt_r <= 3'd0;
                    xor_acc_r  <= 8'h00;
                    timer_r    <= '0;
                    rd_idx_r   <= 3'd0;
                    busy_r     <= 1'b0;
                    if (rx_done) begin
                        ovr_r <= 1'b1;
                    end
                    state_r <= S_IDLE;
                end

                S_IDLE: begin
                    if (rx_done) begin
                        // First byte of a new frame also clears the old drop flag.
                        buf_wr_r    <= 1'b1;
                        buf_wdata_r <= rx_data;
                        byte_cnt_r  <= 3'd1;
                        xor_acc_r   <= rx_data;
                        timer_r     <= '0;
                        frame_err_r <= 1'b0;
                        state_r     <= S_RECV;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end

                S_RECV: begin
                    if (rx_done) begin
                        // A byte on the timeout cycle still wins over the timeout.
                        buf_wr_r    <= 1'b1;
                        buf_wdata_r <= rx_data;
                        byte_cnt_r  <= byte_cnt_r + 3'd1;
                        xor_acc_r   <= xor_fold(xor_acc_r, rx_data);
                        timer_r     <= '0;
                        if ((byte_cnt_r + 3'd1) == FRAME_LEN_V) begin
                            state_r <= S_CHECK;
                        end
                    end else if (timer_r >= TIMEOUT_M1_V) begin
                        // This idle cycle is the one that brings the timer to the limit.
                        timer_r     <= TIMEOUT_V;
                        frame_err_r <= 1'b1;
                        state_r     <= S_CLR;
                    end else begin
                        timer_r <= timer_step(timer_r);
                    end
                end

                S_CHECK: begin
                    if (rx_done) begin
                        ovr_r <= 1'b1;
                    end
                    if (checksum_ok(xor_acc_r)) begin
                        rd_idx_r <= 3'd0;
                        state_r  <= S_FETCH;
                    end else begin
                        frame_err_r <= 1'b1;
                        state_r     <= S_CLR;
                    end
                end

                S_FETCH: begin
                    if (rx_done) begin
                        ovr_r <= 1'b1;
                    end
                    // buf_raddr already shows rd_idx, so buf_rdata is the wanted byte.
                    out_data_r  <= buf_rdata;
                    out_valid_r <= 1'b1;
                    out_last_r  <= (rd_idx_r == LAST_IDX_V);
                    state_r     <= S_OUT;
                end

                S_OUT: begin
                    if (rx_done) begin
                        ovr_r <= 1'b1;
                    end
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (out_last_r) begin
                            // Checksum byte is never read out; frame is finished.
                            rd_idx_r <= 3'd0;
                            state_r  <= S_CLR;
                        end else begin
                            rd_idx_r <= rd_idx_r + 3'd1;
                            state_r  <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state_r <= S_CLR;
                end
            endcase
        end
    end

    assign buf_clr   = buf_clr_r;
    assign buf_wr    = buf_wr_r;
    assign buf_wdata = buf_wdata_r;
    assign buf_raddr = rd_idx_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign frame_err = frame_err_r;
    assign ovr       = ovr_r;
    assign busy      = busy_r;

endmodule
